median_window_sched: RTL
========================

MEDIAN_WINDOW_SCHED -- requirements
Module: median_window_sched

Interface
REQ-001 SHALL have parameter IMG_W, default 13, image width in pixels (>=3).
REQ-002 SHALL have parameter IMG_H, default 13, image height in pixels (>=3).
REQ-003 SHALL have parameter ADDR_W, default 12, pixel memory address width; IMG_W*IMG_H <= 2^ADDR_W.
REQ-004 SHALL have parameter DATA_W, default 8, pixel width.
REQ-005 SHALL have parameter RD_LAT, default 1, memory read latency in cycles (1..3).
REQ-006 SHALL have port clka  input  1  clock; all logic on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-008 SHALL have port start  input  1  begin a frame pass; sampled only in IDLE.
REQ-009 SHALL have port busy  output  1  high from the cycle after an accepted start until DONE.
REQ-010 SHALL have port done  output  1  one-cycle pulse at end of frame.
REQ-011 SHALL have port mem_en  output  1  read strobe to shared single-port pixel memory.
REQ-012 SHALL have port mem_addr  output  ADDR_W  read address.
REQ-013 SHALL have port mem_dout  input  DATA_W  read data, valid RD_LAT cycles after the mem_en cycle.
REQ-014 SHALL have port win_valid  output  1  3x3 window available.
REQ-015 SHALL have port win_ready  input  1  downstream sorter accepts window.
REQ-016 SHALL have port win_data  output  9*DATA_W  packed taps, pk at bits [DATA_W*k +: DATA_W].
REQ-017 SHALL have port win_center  output  ADDR_W  linear address of the window centre pixel.

Function
REQ-018 SHALL process only interior pixels: rows 1..IMG_H-2, cols 1..IMG_W-2, raster order; border pixels produce no window.
REQ-019 SHALL use tap order p0..p8 = c-W-1, c-W, c-W+1, c-1, c, c+1, c+W-1, c+W, c+W+1 (W=IMG_W, c=centre); ADDR_W-bit unsigned arithmetic.
REQ-020 SHALL implement FSM states IDLE, ISSUE, WAIT, PRESENT, DONE.
REQ-021 IDLE: start=1 -> ISSUE next cycle, centre=IMG_W+1, tap counter=0; start=0 -> stay.
REQ-022 ISSUE: mem_en=1, mem_addr=tap address of current tap counter, one tap per cycle for 9 consecutive cycles, then WAIT.
REQ-023 SHALL capture mem_dout into tap register k at the end of the cycle exactly RD_LAT cycles after tap k was issued.
REQ-024 WAIT: mem_en=0; move to PRESENT in the cycle after p8 is captured, so win_valid first rises 9+RD_LAT cycles after the first ISSUE cycle.
REQ-025 PRESENT: win_valid=1; win_data and win_center held stable until win_valid&win_ready.
REQ-026 On handshake: if centre is last interior pixel (row IMG_H-2, col IMG_W-2) -> DONE; else if col==IMG_W-2 -> centre+=3 (next row, col 1), ISSUE; else centre+=1, ISSUE.
REQ-027 DONE: done=1 for exactly one cycle, busy=0, then IDLE.
REQ-028 mem_en SHALL be 0 in every state other than ISSUE; mem_addr don't-care when mem_en=0 but SHALL be held at last value.
REQ-029 start asserted while busy=1 or in DONE SHALL be ignored.
REQ-030 win_ready asserted while win_valid=0 SHALL have no effect.
REQ-031 Total windows per frame SHALL be (IMG_W-2)*(IMG_H-2).

Reset
REQ-032 reset=0 at a rising edge SHALL force IDLE, busy=0, done=0, mem_en=0, win_valid=0, mem_addr=0, win_center=0, win_data=0, tap counter=0, from any state including mid-ISSUE or mid-PRESENT.
REQ-033 Read data returning after a mid-operation reset SHALL be discarded; the next start SHALL begin at centre IMG_W+1.

Verification
REQ-034 Defaults, start pulse, win_ready=1 -> first ISSUE addresses 0,1,2,13,14,15,26,27,28; first window win_center=14, win_valid 10 cycles after first ISSUE cycle; win_data matches memory.
REQ-035 Full frame, win_ready=1 -> exactly 121 windows, last win_center=154, single done pulse, busy low after done.
REQ-036 Row wrap: after window with win_center=24 accepted -> next win_center=27 with taps 13,14,15,26,27,28,39,40,41.
REQ-037 Backpressure: win_ready=0 for 20 cycles during PRESENT -> win_valid, win_data, win_center constant, mem_en=0 throughout; release -> exactly one handshake.
REQ-038 reset=0 for one cycle during ISSUE of window 5 -> all outputs zero next cycle; new start restarts at win_center=14 with correct data.
REQ-039 start pulsed while busy, and RD_LAT=3 run -> no restart, window count unchanged; first win_valid 12 cycles after first ISSUE cycle.

Source files
------------

// File: rtl/median_window_sched.sv
// Raster scheduler for 3x3 median filtering: fetches the nine taps of each interior
// pixel from a single-port memory and presents them to a downstream sorter.
module median_window_sched #(
    parameter int IMG_W  = 13,
    parameter int IMG_H  = 13,
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic                  clka,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_en,
    output logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_dout,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [9*DATA_W-1:0]   win_data,
    output logic [ADDR_W-1:0]     win_center
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, PRESENT, DONE} state_t;

    localparam logic [ADDR_W-1:0] W_A      = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO      = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(IMG_H - 2);

    state_t                   state_q, state_d;
    logic                     busy_q, busy_d, done_q, done_d;
    logic                     mem_en_q, mem_en_d, win_valid_q, win_valid_d;
    logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d, centre_q, centre_d;
    logic [ADDR_W-1:0]        row_q, row_d, col_q, col_d;
    logic [3:0]               tap_q, tap_d;
    logic [8:0][DATA_W-1:0]   taps_q, taps_d;
    logic [RD_LAT:1]          vld_pipe_q, vld_pipe_d;
    logic [RD_LAT:1][3:0]     idx_pipe_q, idx_pipe_d;
    logic [ADDR_W-1:0]        next_c;
    logic                     p8_cap;

    function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] c,
                                                   input logic [3:0] k);
        logic [ADDR_W-1:0] nw;
        nw = c - W_A - ONE;
        case (k)
            4'd0:    tap_addr = nw;
            4'd1:    tap_addr = nw + ONE;
            4'd2:    tap_addr = nw + TWO;
            4'd3:    tap_addr = nw + W_A;
            4'd4:    tap_addr = nw + W_A + ONE;
            4'd5:    tap_addr = nw + W_A + TWO;
            4'd6:    tap_addr = nw + W_A + W_A;
            4'd7:    tap_addr = nw + W_A + W_A + ONE;
            4'd8:    tap_addr = nw + W_A + W_A + TWO;
            default: tap_addr = nw;
        endcase
    endfunction

    // Read-return tracker: each issued tap travels RD_LAT stages with its index, so
    // data is written to the right tap slot; clearing it on reset drops stale returns.
    always_comb begin
        vld_pipe_d    = vld_pipe_q;
        idx_pipe_d    = idx_pipe_q;
        vld_pipe_d[1] = mem_en_q;
        idx_pipe_d[1] = tap_q;
        for (int i = 2; i <= RD_LAT; i++) begin
            vld_pipe_d[i] = vld_pipe_q[i-1];
            idx_pipe_d[i] = idx_pipe_q[i-1];
        end
        taps_d = taps_q;
        if (vld_pipe_q[RD_LAT])
            taps_d[idx_pipe_q[RD_LAT]] = mem_dout;
        p8_cap = vld_pipe_q[RD_LAT] && (idx_pipe_q[RD_LAT] == 4'd8);
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mem_en_d    = mem_en_q;
        mem_addr_d  = mem_addr_q;
        win_valid_d = win_valid_q;
        centre_d    = centre_q;
        row_d       = row_q;
        col_d       = col_q;
        tap_d       = tap_q;
        next_c      = (col_q == LAST_COL) ? centre_q + ADDR_W'(3) : centre_q + ONE;
        case (state_q)
            IDLE: if (start) begin
                state_d    = ISSUE;
                busy_d     = 1'b1;
                centre_d   = W_A + ONE;
                row_d      = ONE;
                col_d      = ONE;
                tap_d      = 4'd0;
                mem_en_d   = 1'b1;
                mem_addr_d = tap_addr(W_A + ONE, 4'd0);
            end
            ISSUE: if (tap_q == 4'd8) begin
                state_d  = WAIT;
                mem_en_d = 1'b0;
                tap_d    = 4'd0;
            end else begin
                tap_d      = tap_q + 4'd1;
                mem_addr_d = tap_addr(centre_q, tap_q + 4'd1);
            end
            WAIT: if (p8_cap) begin
                state_d     = PRESENT;
                win_valid_d = 1'b1;
            end
            PRESENT: if (win_ready) begin
                win_valid_d = 1'b0;
                if (row_q == LAST_ROW && col_q == LAST_COL) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d    = ISSUE;
                    centre_d   = next_c;
                    row_d      = (col_q == LAST_COL) ? row_q + ONE : row_q;
                    col_d      = (col_q == LAST_COL) ? ONE : col_q + ONE;
                    tap_d      = 4'd0;
                    mem_en_d   = 1'b1;
                    mem_addr_d = tap_addr(next_c, 4'd0);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clka) begin
        if (!reset) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_addr_q  <= '0;
            win_valid_q <= 1'b0;
            centre_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            tap_q       <= '0;
            taps_q      <= '0;
            vld_pipe_q  <= '0;
            idx_pipe_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_en_q    <= mem_en_d;
            mem_addr_q  <= mem_addr_d;
            win_valid_q <= win_valid_d;
            centre_q    <= centre_d;
            row_q       <= row_d;
            col_q       <= col_d;
            tap_q       <= tap_d;
            taps_q      <= taps_d;
            vld_pipe_q  <= vld_pipe_d;
            idx_pipe_q  <= idx_pipe_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign mem_en     = mem_en_q;
    assign mem_addr   = mem_addr_q;
    assign win_valid  = win_valid_q;
    assign win_data   = taps_q;
    assign win_center = centre_q;
endmodule
